conv_ctrl: RTL
==============

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter word_length, default 8, pixel/weight bit width.
REQ-002 SHALL have parameter kernel_size, default 5, kernel edge length (K).
REQ-003 SHALL have parameter image_size, default 36, input image edge length (N).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to run one convolution frame.
REQ-007 SHALL have port w_valid  input  1  weight beat present.
REQ-008 SHALL have port w_data  input  word_length  serial weight beat.
REQ-009 SHALL have port w_ready  output  1  weight beat accepted when w_valid&w_ready.
REQ-010 SHALL have port pix_valid  input  1  pixel beat present.
REQ-011 SHALL have port pix_data  input  word_length  raster-order pixel.
REQ-012 SHALL have port pix_ready  output  1  pixel beat accepted when pix_valid&pix_ready.
REQ-013 SHALL have port conv_clr  output  1  one-cycle clear pulse to datapath.
REQ-014 SHALL have port conv_in_valid  output  1  datapath pixel strobe.
REQ-015 SHALL have port conv_data_in  output  word_length  datapath pixel.
REQ-016 SHALL have port weight_value  output  K*K*word_length  packed kernel.
REQ-017 SHALL have port conv_res_valid  input  1  datapath result strobe.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle end-of-frame pulse.
REQ-020 SHALL have port res_count  output  16  results received in current frame.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-022 SHALL go IDLE->LOAD_W on start; start in any other state SHALL be ignored.
REQ-023 SHALL assert conv_clr for exactly the first cycle in LOAD_W and clear weight index, pixel count, res_count in that transition.
REQ-024 SHALL assert w_ready only in LOAD_W; beat k (0-based) stored at weight_value[k*word_length +: word_length].
REQ-025 SHALL go LOAD_W->STREAM in the cycle after the K*K-th accepted weight beat; weight_value SHALL hold stable until next LOAD_W.
REQ-026 SHALL assert pix_ready only in STREAM; accepted beat SHALL appear on conv_data_in with conv_in_valid high exactly 1 cycle later, conv_in_valid low otherwise.
REQ-027 SHALL go STREAM->DRAIN after the N*N-th accepted pixel (1296 default); pix_ready SHALL drop the cycle after.
REQ-028 SHALL increment res_count per conv_res_valid in STREAM or DRAIN, saturating at (N-K+1)^2 (1024 default); strobes in IDLE/LOAD_W/DONE SHALL be ignored.
REQ-029 SHALL go DRAIN->DONE when res_count reaches (N-K+1)^2, including when reached during STREAM (DONE entered after STREAM->DRAIN).
REQ-030 SHALL pulse done for the single DONE cycle then return to IDLE; res_count SHALL hold its final value in IDLE.
REQ-031 SHALL treat w_valid/pix_valid gaps as stalls with no count change and no timeout.

Reset
REQ-032 SHALL on rst force IDLE and zero w_ready, pix_ready, conv_clr, conv_in_valid, conv_data_in, weight_value, busy, done, res_count, all counters.
REQ-033 SHALL on rst mid-frame abandon the frame without done; next start SHALL run a full frame.

Structure
REQ-034 SHALL place FSM state encoding and derived constants K*K, N*N, (N-K+1)^2 in shared package conv_pkg.
REQ-035 SHALL keep weight shift/index logic in one sub-module conv_weight_loader; all else flat.

Verification
REQ-036 SHALL test reset: rst mid-STREAM -> IDLE, busy=0, res_count=0, no done.
REQ-037 SHALL test weights 1..25 contiguous -> weight_value[7:0]=1, [199:192]=25, STREAM after cycle 25.
REQ-038 SHALL test full frame, no stalls, 1296 pixels, model returning 1024 strobes -> done once, res_count=1024.
REQ-039 SHALL test random pix_valid gaps -> conv_in_valid count=1296, each pixel 1-cycle delayed, order preserved.
REQ-040 SHALL test start pulsed in STREAM and extra strobes after 1024 -> ignored, res_count stays 1024.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared FSM encoding and frame-size helpers for the convolution controller.
// Derived constants are computed from the kernel/image edge lengths.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic int unsigned sq_f(
    input int unsigned x
  );
    return x * x;
  endfunction

  // Valid-window output count for an N x N image and K x K kernel.
  function automatic int unsigned res_total_f(
    input int unsigned n,
    input int unsigned k
  );
    return sq_f(n - k + 1);
  endfunction

  localparam int unsigned KER_DEF  = 5;
  localparam int unsigned IMG_DEF  = 36;
  localparam int unsigned KK_DEF   = sq_f(KER_DEF);
  localparam int unsigned NN_DEF   = sq_f(IMG_DEF);
  localparam int unsigned RES_DEF  = res_total_f(IMG_DEF, KER_DEF);
  localparam int unsigned RES_CW   = 16;

endpackage

// File: rtl/conv_weight_loader.sv
// Serial-to-parallel kernel loader: beat k lands in slot k of weight_o.
// Ports: clr_i restarts indexing, beat_i stores data_i, last_o flags slot K*K-1.
module conv_weight_loader
  import conv_pkg::*;
#(
  parameter int unsigned word_length = 8,
  parameter int unsigned kernel_size = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic beat_i,
  input  logic [word_length-1:0] data_i,
  output logic [kernel_size*kernel_size*word_length-1:0] weight_o,
  output logic last_o
);

  localparam int unsigned KK = sq_f(kernel_size);
  localparam int unsigned IW = $clog2(KK + 1);

  logic [IW-1:0] idx_q, idx_d;
  logic [KK*word_length-1:0] w_q, w_d;

  always_comb begin
    w_d   = w_q;
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (beat_i) begin
      idx_d = idx_q + 1'b1;
      for (int k = 0; k < KK; k++) begin
        if (idx_q == IW'(k)) begin
          w_d[k*word_length +: word_length] = data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q   <= '0;
      idx_q <= '0;
    end else begin
      w_q   <= w_d;
      idx_q <= idx_d;
    end
  end

  assign weight_o = w_q;
  assign last_o   = (idx_q == IW'(KK - 1));

endmodule

// File: rtl/conv_ctrl.sv
// Frame sequencer for a convolution datapath: loads a kernel, streams pixels,
// counts results. Ports: start/w_*/pix_* in, conv_* to datapath, busy/done/res_count.
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned word_length = 8,
  parameter int unsigned kernel_size = 5,
  parameter int unsigned image_size  = 36
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic w_valid,
  input  logic [word_length-1:0] w_data,
  output logic w_ready,
  input  logic pix_valid,
  input  logic [word_length-1:0] pix_data,
  output logic pix_ready,
  output logic conv_clr,
  output logic conv_in_valid,
  output logic [word_length-1:0] conv_data_in,
  output logic [kernel_size*kernel_size*word_length-1:0] weight_value,
  input  logic conv_res_valid,
  output logic busy,
  output logic done,
  output logic [15:0] res_count
);

  localparam int unsigned NN = sq_f(image_size);
  localparam int unsigned RT = res_total_f(image_size, kernel_size);
  localparam int unsigned PW = $clog2(NN + 1);

  state_e state_q, state_d;

  logic [PW-1:0] pix_cnt_q;
  logic [15:0]   res_cnt_q;
  logic          frame_start;
  logic          w_beat;
  logic          w_last;
  logic          pix_beat;
  logic          pix_last;
  logic          res_full;
  logic          res_take;

  // Beats are qualified by state, not by the ready outputs, to keep the
  // handshake free of combinational feedback through the FSM block.
  assign frame_start = (state_q == S_IDLE) && start;
  assign w_beat      = (state_q == S_LOAD_W) && w_valid;
  assign pix_beat    = (state_q == S_STREAM) && pix_valid;
  assign pix_last    = pix_beat && (pix_cnt_q == PW'(NN - 1));
  assign res_full    = (res_cnt_q == 16'(RT));
  assign res_take    = conv_res_valid && !res_full
                    && ((state_q == S_STREAM) || (state_q == S_DRAIN));

  conv_weight_loader #(
    .word_length(word_length),
    .kernel_size(kernel_size)
  ) u_wload (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (frame_start),
    .beat_i  (w_beat),
    .data_i  (w_data),
    .weight_o(weight_value),
    .last_o  (w_last)
  );

  always_comb begin
    state_d   = state_q;
    w_ready   = 1'b0;
    pix_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_beat && w_last) state_d = S_STREAM;
      end
      S_STREAM: begin
        pix_ready = 1'b1;
        if (pix_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_full) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      conv_clr      <= 1'b0;
      conv_in_valid <= 1'b0;
      conv_data_in  <= '0;
      pix_cnt_q     <= '0;
      res_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      conv_clr      <= frame_start;
      conv_in_valid <= pix_beat;
      if (pix_beat) conv_data_in <= pix_data;
      if (frame_start) begin
        pix_cnt_q <= '0;
        res_cnt_q <= '0;
      end else begin
        if (pix_beat) pix_cnt_q <= pix_cnt_q + 1'b1;
        if (res_take) res_cnt_q <= res_cnt_q + 16'd1;
      end
    end
  end

  assign res_count = res_cnt_q;

endmodule
